// File: rtl/face_result_fifo.sv
// Per-frame detection buffer between detect_face and the host result path, with a valid/ready
// output stream and last-of-frame tagging. Optional duplicate suppression: define FACE_DEDUP_EN.
module face_result_fifo #(
  parameter int COORD_W    = 32,
  parameter int PYR_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int DEDUP_DIST = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic                        face_coords_ready,
  input  logic [1:0][COORD_W-1:0]     face_coords,
  input  logic [PYR_W-1:0]            pyramid_number,
  input  logic                        vj_pipeline_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COORD_W-1:0]          out_row,
  output logic [COORD_W-1:0]          out_col,
  output logic [PYR_W-1:0]            out_pyramid,
  output logic                        out_last,
  output logic                        frame_done,
  output logic [CNT_W-1:0]            face_count,
  output logic [CNT_W-1:0]            drop_count,
  output logic                        overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

`ifdef FACE_DEDUP_EN
  localparam bit DEDUP_ON = 1'b1;
`else
  localparam bit DEDUP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occupancy;
  logic [CNT_W-1:0]   face_count_q, face_count_d, drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;
  logic [COORD_W-1:0] last_row_q, last_row_d, last_col_q, last_col_d;
  logic [PYR_W-1:0]   last_pyr_q, last_pyr_d;
  logic               last_vld_q, last_vld_d;

  logic [COORD_W-1:0] mem_row [DEPTH];
  logic [COORD_W-1:0] mem_col [DEPTH];
  logic [PYR_W-1:0]   mem_pyr [DEPTH];

  logic clear_frame, push_req, full, pop, push, dup_hit, drop_full, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic near(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= COORD_W'(DEDUP_DIST);
  endfunction

  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign full        = (occupancy == PTR_W'(DEPTH));
  assign clear_frame = (state_q == IDLE) && frame_start;
  assign push_req    = (state_q == COLLECT) && face_coords_ready;

  // Holding back the newest entry while collecting lets the true final entry carry out_last.
  assign out_valid = ((state_q == COLLECT) && (occupancy >= PTR_W'(2))) ||
                     ((state_q == DRAIN)   && (occupancy != '0));
  assign out_last   = (state_q == DRAIN) && (occupancy == PTR_W'(1));
  assign frame_done = (state_q == DRAIN) && (occupancy == '0);
  assign pop        = out_valid && out_ready;

  assign dup_hit   = DEDUP_ON && last_vld_q && (pyramid_number == last_pyr_q) &&
                     near(face_coords[0], last_row_q) && near(face_coords[1], last_col_q);
  assign push      = push_req && !dup_hit && (!full || pop);
  assign drop_full = push_req && !dup_hit && full && !pop;
  assign drop      = drop_full || (push_req && dup_hit);

  assign out_row     = out_valid ? mem_row[rd_ptr_q[AW-1:0]] : '0;
  assign out_col     = out_valid ? mem_col[rd_ptr_q[AW-1:0]] : '0;
  assign out_pyramid = out_valid ? mem_pyr[rd_ptr_q[AW-1:0]] : '0;
  assign face_count  = face_count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = COLLECT;
      COLLECT: if (vj_pipeline_done) state_d = DRAIN;
      DRAIN:   if (occupancy == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    face_count_d = face_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    last_row_d   = last_row_q;
    last_col_d   = last_col_q;
    last_pyr_d   = last_pyr_q;
    last_vld_d   = last_vld_q;
    if (clear_frame) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      face_count_d = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
      last_vld_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        face_count_d = sat_inc(face_count_q);
        last_row_d   = face_coords[0];
        last_col_d   = face_coords[1];
        last_pyr_d   = pyramid_number;
        last_vld_d   = 1'b1;
      end
      if (pop)       rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      if (drop)      drop_count_d = sat_inc(drop_count_q);
      if (drop_full) overflow_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      face_count_q <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      last_row_q   <= '0;
      last_col_q   <= '0;
      last_pyr_q   <= '0;
      last_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      face_count_q <= face_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      last_row_q   <= last_row_d;
      last_col_q   <= last_col_d;
      last_pyr_q   <= last_pyr_d;
      last_vld_q   <= last_vld_d;
    end
  end

  // Storage is written only on accepted pushes; reads are masked by out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_row[wr_ptr_q[AW-1:0]] <= face_coords[0];
      mem_col[wr_ptr_q[AW-1:0]] <= face_coords[1];
      mem_pyr[wr_ptr_q[AW-1:0]] <= pyramid_number;
    end
  end

endmodule

// File: tb/tb_face_result_fifo.sv
// Directed bench for face_result_fifo: frame flow, hold-back tagging, overflow, stall, async reset, dedup.
module tb_face_result_fifo;

  localparam int COORD_W = 32;
  localparam int PYR_W   = 4;
  localparam int CNT_W   = 16;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    frame_start = 1'b0;
  logic                    face_coords_ready = 1'b0;
  logic [1:0][COORD_W-1:0] face_coords = '0;
  logic [PYR_W-1:0]        pyramid_number = '0;
  logic                    vj_pipeline_done = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [COORD_W-1:0]      out_row, out_col;
  logic [PYR_W-1:0]        out_pyramid;
  logic                    out_last, frame_done, overflow;
  logic [CNT_W-1:0]        face_count, drop_count;

  int n_chk = 0;
  int n_fail = 0;

  face_result_fifo #(.COORD_W(COORD_W), .PYR_W(PYR_W), .DEPTH(16), .CNT_W(CNT_W), .DEDUP_DIST(2)) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
    .face_coords_ready(face_coords_ready), .face_coords(face_coords),
    .pyramid_number(pyramid_number), .vj_pipeline_done(vj_pipeline_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .out_pyramid(out_pyramid), .out_last(out_last), .frame_done(frame_done),
    .face_count(face_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic det(input logic v, input int r, input int c, input int p);
    face_coords_ready = v;
    face_coords[0]    = COORD_W'(r);
    face_coords[1]    = COORD_W'(c);
    pyramid_number    = PYR_W'(p);
  endtask

  int exp_n;

  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", face_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", frame_done, 0);
    step(); step();
    reset_n = 1'b1;

    // T1: three detections, normal drain
    frame_start = 1; step(); frame_start = 0;
    det(1, 10, 20, 0); step();
    check("t1_holdback", out_valid, 0);
    det(1, 10, 40, 1); step();
    check("t1_valid2", out_valid, 1);
    check("t1_head_row", out_row, 10);
    check("t1_head_col", out_col, 20);
    check("t1_last_collect", out_last, 0);
    det(1, 50, 5, 2); vj_pipeline_done = 1; step();
    det(0, 0, 0, 0); vj_pipeline_done = 0;
    check("t1_count", face_count, 3);
    check("t1_last_occ3", out_last, 0);
    out_ready = 1;
    step();
    check("t1_b2_col", out_col, 40);
    check("t1_b2_pyr", out_pyramid, 1);
    check("t1_b2_last", out_last, 0);
    step();
    check("t1_b3_row", out_row, 50);
    check("t1_b3_pyr", out_pyramid, 2);
    check("t1_b3_last", out_last, 1);
    check("t1_b3_fdone", frame_done, 0);
    step();
    check("t1_empty_valid", out_valid, 0);
    check("t1_fdone", frame_done, 1);
    step();
    check("t1_fdone_pulse", frame_done, 0);
    check("t1_count_hold", face_count, 3);
    out_ready = 0;

    // T2: empty frame
    frame_start = 1; step(); frame_start = 0;
    check("t2_count_clr", face_count, 0);
    vj_pipeline_done = 1; step(); vj_pipeline_done = 0;
    check("t2_fdone", frame_done, 1);
    check("t2_valid", out_valid, 0);
    step();
    check("t2_fdone_pulse", frame_done, 0);
    check("t2_valid_idle", out_valid, 0);

    // T3: 20 pushes into 16 entries with consumer stalled
    frame_start = 1; step(); frame_start = 0;
    for (int i = 0; i < 20; i++) begin
      det(1, 100 + i, 200 + i, i); step();
    end
    det(0, 0, 0, 0);
    check("t3_count", face_count, 16);
    check("t3_drop", drop_count, 4);
    check("t3_ovf", overflow, 1);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_row, 100);
    vj_pipeline_done = 1; step(); vj_pipeline_done = 0;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("t3_beat_row", out_row, 100 + i);
      check("t3_beat_last", out_last, (i == 15) ? 1 : 0);
      step();
    end
    check("t3_fdone", frame_done, 1);
    step();
    out_ready = 0;

    // T3b: push into a full FIFO while popping
    frame_start = 1; step(); frame_start = 0;
    for (int i = 0; i < 16; i++) begin
      det(1, i, 50 + i, i); step();
    end
    det(1, 99, 98, 0); out_ready = 1; step();
    det(0, 0, 0, 0); out_ready = 0;
    check("t3b_drop", drop_count, 0);
    check("t3b_ovf", overflow, 0);
    check("t3b_count", face_count, 17);
    check("t3b_head", out_row, 1);
    vj_pipeline_done = 1; step(); vj_pipeline_done = 0;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("t3b_beat_row", out_row, (i < 15) ? i + 1 : 99);
      step();
    end
    check("t3b_fdone", frame_done, 1);
    step();
    out_ready = 0;

    // T4: push and done together, then a stalled head
    frame_start = 1; step(); frame_start = 0;
    det(1, 7, 8, 3); vj_pipeline_done = 1; step();
    det(0, 0, 0, 0); vj_pipeline_done = 0;
    check("t4_valid", out_valid, 1);
    check("t4_row", out_row, 7);
    check("t4_last", out_last, 1);
    step();
    check("t4_stall_valid", out_valid, 1);
    check("t4_stall_col", out_col, 8);
    check("t4_stall_pyr", out_pyramid, 3);
    step();
    check("t4_stall2_row", out_row, 7);
    out_ready = 1; step(); out_ready = 0;
    check("t4_fdone", frame_done, 1);
    check("t4_empty", out_valid, 0);
    step();

    // T5: asynchronous reset in the middle of a drain
    frame_start = 1; step(); frame_start = 0;
    det(1, 1, 2, 1); step();
    det(1, 3, 4, 2); step();
    det(0, 0, 0, 0); vj_pipeline_done = 1; step(); vj_pipeline_done = 0;
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_count", face_count, 2);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_row", out_row, 0);
    check("t5_rst_count", face_count, 0);
    check("t5_rst_fdone", frame_done, 0);
    step();
    reset_n = 1'b1;
    frame_start = 1; step(); frame_start = 0;
    det(1, 9, 9, 0); step();
    det(1, 8, 8, 1); vj_pipeline_done = 1; step();
    det(0, 0, 0, 0); vj_pipeline_done = 0;
    check("t5_count", face_count, 2);
    check("t5_head", out_row, 9);
    out_ready = 1; step();
    check("t5_b2_row", out_row, 8);
    check("t5_b2_last", out_last, 1);
    step();
    check("t5_fdone", frame_done, 1);
    step();
    out_ready = 0;

    // T6: near-duplicate detections
`ifdef FACE_DEDUP_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    frame_start = 1; step(); frame_start = 0;
    det(1, 10, 10, 0); step();
    det(1, 11, 12, 0); step();
    det(1, 11, 12, 1); vj_pipeline_done = 1; step();
    det(0, 0, 0, 0); vj_pipeline_done = 0;
    check("t6_count", face_count, exp_n);
    check("t6_drop", drop_count, 3 - exp_n);
    check("t6_ovf", overflow, 0);
    check("t6_head_col", out_col, 10);
    out_ready = 1;
    for (int i = 0; i < exp_n - 1; i++) step();
    check("t6_tail_row", out_row, 11);
    check("t6_tail_pyr", out_pyramid, 1);
    check("t6_tail_last", out_last, 1);
    step();
    check("t6_fdone", frame_done, 1);
    step();
    out_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
